pe_result_drain: RTL and testbench
==================================

Name: pe_result_drain

Overview:
- Receiving end of the PE output interface: consumes the PE output packet (accumulated data plus PE state) and captures a result on each PE_DONE.
- Post-processes each result: arithmetic rescale, optional ReLU, signed saturation to OUT_WID.
- Buffers results in a small FIFO and presents them downstream on a valid/ready stream, with an output-channel index and last flag.
- Raises an early hold to the PE controller, because the 3-stage PE pipeline cannot be stalled mid-flight.

Parameters:
- DATA_WID, `CNN_XLEN, width of the PE accumulator data.
- OUT_WID, 8, width of the quantized output word.
- FRAC_SHIFT, 4, arithmetic right shift applied before saturation.
- FIFO_DEPTH, 4, result FIFO entries (power of two, >=2).
- HOLD_MARGIN, 3, pe_hold asserts when free entries <= HOLD_MARGIN.
- OUT_CNT, 16, results per output group; sets the out_idx wrap point.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pe_out_pk  input  PE_OUT_PACKET  PE result packet: .data (signed DATA_WID) and .PE_state.
- relu_en  input  1  ReLU enable, sampled together with the capture.
- pe_hold  output  1  tells the PE controller to stop issuing new accumulations.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts a word.
- out_data  output  OUT_WID  quantized signed result.
- out_idx  output  $clog2(OUT_CNT)  index of the current head word within its group.
- out_last  output  1  head word is the final word of its group (out_idx == OUT_CNT-1).
- overflow_err  output  1  sticky: a result was dropped.

Behaviour:
- Reset (async, active-high): all outputs 0; FIFO count, read pointer and write pointer 0; capture stage invalid. Reset mid-stream discards all buffered results.
- Capture (stage C): when pe_out_pk.PE_state == PE_DONE, register .data and relu_en and set cap_valid for one cycle. All other states are ignored.
- Post-process, combinational on the stage C register, in this order:
  - s = data >>> FRAC_SHIFT (sign-preserving).
  - If relu_en and s < 0, then s = 0.
  - Saturate s to [-2^(OUT_WID-1), 2^(OUT_WID-1)-1].
- Enqueue: the post-processed word is written to the FIFO on the cycle after capture.
- Latency: PE_DONE at cycle N, FIFO empty, out_ready=1 -> out_valid=1 with the word at cycle N+2.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - out_valid == (count != 0).
  - Once out_valid is high, out_data is held stable until transferred.
- Push/pop:
  - Push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: a push that is not accepted drops the word and sets overflow_err. overflow_err clears only on reset.
- pe_hold:
  - Registered; equals ((FIFO_DEPTH - count - cap_valid) <= HOLD_MARGIN) from the previous cycle.
  - It is advisory only; the block never backpressures the PE data path.
- out_idx:
  - Increments on each transfer and wraps from OUT_CNT-1 to 0.
  - It is a count of transferred words and does not depend on data values.
- No combinational path from out_ready to out_valid. out_data comes from the FIFO head register or read mux.

Decomposition:
- Shared package:
  - PE_OUT_PACKET and PE_STATE already exist there; this block relies on their PE_DONE encoding.
  - Add a RESULT_WORD typedef (data[OUT_WID] + idx + last).
  - Add the OUT_WID and FRAC_SHIFT defaults as `defines beside `CNN_XLEN.
- One sub-module: sync_fifo (parameterized width and depth, with count output), reusable elsewhere.
- Quantization logic stays inline.

Test Plan (DATA_WID=16, OUT_WID=8, FRAC_SHIFT=4, FIFO_DEPTH=4, HOLD_MARGIN=1, OUT_CNT=3):
- Single result: data=0x0123 with PE_DONE at cycle N, out_ready=1 -> out_valid at N+2 with out_data=0x12, out_idx=0, out_last=0.
- ReLU: data=0xFE00 (-512). With relu_en=1 -> out_data=0x00. With relu_en=0 -> out_data=0xE0 (-32).
- Saturation: data=0x7FF0 -> 0x7F. data=0x8000 with relu_en=0 -> 0x80. Neither drop sets overflow_err.
- Backpressure and overflow: out_ready=0 and 5 PE_DONE pulses (values 1..5 <<4) -> pe_hold rises after the 3rd capture, overflow_err=1 after the 5th. Then out_ready=1 -> exactly 0x01,0x02,0x03,0x04 in order; out_last on the 3rd; out_idx sequence 0,1,2,0.
- Simultaneous push/pop at full: FIFO full, out_ready=1, PE_DONE present -> word accepted, count stays 4, overflow_err stays 0.
- Reset mid-stream: 2 words buffered, assert reset asynchronously -> out_valid=0, pe_hold=0, overflow_err=0, out_idx=0 immediately. The next result after release appears with idx 0.

Source files
------------

// File: rtl/pe_result_drain_pkg.sv
// ---------------------------------------------------------------------------
// pe_result_drain_pkg
// Shared PE interface types plus the drain-side result word.
//   PE_STATE      : PE controller state encoding (PE_DONE marks a finished
//                   accumulation whose data is valid on the packet).
//   PE_OUT_PACKET : PE output packet = accumulated data + PE state.
//   RESULT_WORD   : quantized result as seen downstream (data, idx, last).
// Width defaults live here as defines so every block agrees on them.
// ---------------------------------------------------------------------------
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef OUT_WID
`define OUT_WID 8
`endif
`ifndef FRAC_SHIFT
`define FRAC_SHIFT 4
`endif

package pe_result_drain_pkg;

    typedef enum logic [1:0] {
        PE_IDLE = 2'd0,
        PE_LOAD = 2'd1,
        PE_ACC  = 2'd2,
        PE_DONE = 2'd3
    } PE_STATE;

    typedef struct packed {
        logic signed [`CNN_XLEN-1:0] data;
        PE_STATE                     PE_state;
    } PE_OUT_PACKET;

    // Index width for the default group size of 16 results.
    localparam int RESULT_IDX_WID = 4;

    typedef struct packed {
        logic [`OUT_WID-1:0]       data;
        logic [RESULT_IDX_WID-1:0] idx;
        logic                      last;
    } RESULT_WORD;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with occupancy count. DEPTH must be a power of two so
// the pointers wrap naturally.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push       : request to write push_data
//   push_data  : write data
//   pop        : remove head entry (ignored when empty)
//   head_data  : current head entry (read mux on the read pointer)
//   count      : number of stored entries, 0..DEPTH
//   drop       : push requested but not accepted this cycle
// A push into a full FIFO is still accepted when a pop happens in the same
// cycle: the head leaves on the same edge the new word lands.
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok    = pop && (count != '0);
    assign push_ok   = push && ((count < CW'(DEPTH)) || pop_ok);
    assign drop      = push && !push_ok;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pe_result_drain.sv
// ---------------------------------------------------------------------------
// pe_result_drain
// Receives PE output packets, captures the data on PE_DONE, rescales,
// optionally rectifies and saturates it, buffers it and streams it out.
//   clk, reset   : clock, asynchronous active-high reset
//   pe_out_pk    : PE result packet (data + PE_state)
//   relu_en      : ReLU enable, captured with the data
//   pe_hold      : advisory hold to the PE controller (registered)
//   out_valid    : out_data holds a result
//   out_ready    : downstream accepts the word
//   out_data     : quantized signed result
//   out_idx      : position of the head word within its output group
//   out_last     : head word is the final word of its group
//   overflow_err : sticky, a result was dropped because the FIFO was full
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. out_valid depends only on registered FIFO state
// (never on out_ready), and once high the word stays put until it transfers.
// ---------------------------------------------------------------------------
module pe_result_drain
    import pe_result_drain_pkg::*;
#(
    parameter  int DATA_WID    = `CNN_XLEN,
    parameter  int OUT_WID     = `OUT_WID,
    parameter  int FRAC_SHIFT  = `FRAC_SHIFT,
    parameter  int FIFO_DEPTH  = 4,
    parameter  int HOLD_MARGIN = 3,
    parameter  int OUT_CNT     = 16,
    localparam int IDX_WID     = $clog2(OUT_CNT),
    localparam int CNT_WID     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  PE_OUT_PACKET       pe_out_pk,
    input  logic               relu_en,
    output logic               pe_hold,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_WID-1:0] out_data,
    output logic [IDX_WID-1:0] out_idx,
    output logic               out_last,
    output logic               overflow_err
);

    localparam logic signed [DATA_WID-1:0] SAT_MAX = DATA_WID'((1 << (OUT_WID - 1)) - 1);
    localparam logic signed [DATA_WID-1:0] SAT_MIN = ~SAT_MAX;

    // Capture stage
    logic                       cap_valid;
    logic signed [DATA_WID-1:0] cap_data;
    logic                       cap_relu;
    logic                       pe_done;

    assign pe_done = (pe_out_pk.PE_state == PE_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_valid <= 1'b0;
            cap_data  <= '0;
            cap_relu  <= 1'b0;
        end else begin
            cap_valid <= pe_done;
            if (pe_done) begin
                cap_data <= pe_out_pk.data[DATA_WID-1:0];
                cap_relu <= relu_en;
            end
        end
    end

    // Quantization: shift, rectify, then clamp into the OUT_WID signed range.
    logic signed [DATA_WID-1:0] shifted;
    logic signed [DATA_WID-1:0] rectified;
    logic        [OUT_WID-1:0]  q_word;

    always_comb begin
        shifted   = cap_data >>> FRAC_SHIFT;
        rectified = (cap_relu && shifted[DATA_WID-1]) ? '0 : shifted;
        if (rectified > SAT_MAX)      q_word = SAT_MAX[OUT_WID-1:0];
        else if (rectified < SAT_MIN) q_word = SAT_MIN[OUT_WID-1:0];
        else                          q_word = rectified[OUT_WID-1:0];
    end

    // Result buffer
    logic [OUT_WID-1:0] head_data;
    logic [CNT_WID-1:0] fifo_count;
    logic               fifo_drop;
    logic               xfer;

    assign out_valid = (fifo_count != '0);
    assign xfer      = out_valid && out_ready;
    assign out_data  = out_valid ? head_data : '0;
    assign out_last  = (out_idx == IDX_WID'(OUT_CNT - 1));

    sync_fifo #(
        .WIDTH (OUT_WID),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cap_valid),
        .push_data (q_word),
        .pop       (xfer),
        .head_data (head_data),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    // The hold counts the word sitting in the capture stage as already
    // occupying a slot, since it will be written regardless of pe_hold.
    logic hold_next;

    always_comb begin
        hold_next = (FIFO_DEPTH - int'(fifo_count) - int'(cap_valid)) <= HOLD_MARGIN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe_hold      <= 1'b0;
            overflow_err <= 1'b0;
            out_idx      <= '0;
        end else begin
            pe_hold <= hold_next;
            if (fifo_drop) overflow_err <= 1'b1;
            if (xfer) begin
                out_idx <= (out_idx == IDX_WID'(OUT_CNT - 1)) ? '0 : out_idx + IDX_WID'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_result_drain.sv
// ---------------------------------------------------------------------------
// tb_pe_result_drain
// Quantization vector table, directed multi-cycle sequences (backpressure,
// overflow, push/pop at full, asynchronous reset) and a randomized run, all
// checked every cycle against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pe_result_drain;
    import pe_result_drain_pkg::*;

    localparam int DATA_WID    = 16;
    localparam int OUT_WID     = 8;
    localparam int FRAC_SHIFT  = 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int HOLD_MARGIN = 1;
    localparam int OUT_CNT     = 3;
    localparam int IDX_WID     = $clog2(OUT_CNT);

    // ---------------- clock / reset ----------------
    logic               clk = 1'b0;
    logic               reset;
    PE_OUT_PACKET       pe_out_pk;
    logic               relu_en;
    logic               pe_hold;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_WID-1:0] out_data;
    logic [IDX_WID-1:0] out_idx;
    logic               out_last;
    logic               overflow_err;

    always #5 clk = ~clk;

    pe_result_drain #(
        .DATA_WID    (DATA_WID),
        .OUT_WID     (OUT_WID),
        .FRAC_SHIFT  (FRAC_SHIFT),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .HOLD_MARGIN (HOLD_MARGIN),
        .OUT_CNT     (OUT_CNT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pe_out_pk    (pe_out_pk),
        .relu_en      (relu_en),
        .pe_hold      (pe_hold),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .overflow_err (overflow_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [OUT_WID-1:0] exp_q[$];
    bit                 pend_v;
    logic [OUT_WID-1:0] pend_w;
    int                 m_idx;
    bit                 m_ovf;
    bit                 m_hold;

    function automatic logic [OUT_WID-1:0] ref_quant(input logic [DATA_WID-1:0] raw, input logic relu);
        int v;
        v = int'($signed(raw));
        v = v >>> FRAC_SHIFT;
        if (relu && v < 0) v = 0;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return OUT_WID'(v);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend_v = 0;
        pend_w = '0;
        m_idx  = 0;
        m_ovf  = 0;
        m_hold = 0;
    endtask

    // One clock edge of the specified behaviour.
    task automatic model_step(input bit done, input logic [DATA_WID-1:0] d, input logic relu, input logic rdy);
        int occ;
        bit had_pend;
        occ      = exp_q.size();
        had_pend = pend_v;
        if (occ != 0 && rdy) begin
            void'(exp_q.pop_front());
            m_idx = (m_idx + 1) % OUT_CNT;
        end
        if (had_pend) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pend_w);
            else                           m_ovf = 1;
        end
        m_hold = (FIFO_DEPTH - occ - int'(had_pend)) <= HOLD_MARGIN;
        pend_v = done;
        pend_w = ref_quant(d, relu);
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
        check("out_idx", out_idx, m_idx);
        check("out_last", out_last, m_idx == OUT_CNT - 1);
        check("pe_hold", pe_hold, m_hold);
        check("overflow_err", overflow_err, m_ovf);
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        pe_out_pk.data     = '0;
        pe_out_pk.PE_state = PE_IDLE;
        relu_en            = 1'b0;
        out_ready          = 1'b0;
    endtask

    // Called just after a falling edge: drive, clock, then check at the next fall.
    task automatic cycle(input PE_STATE st, input logic [DATA_WID-1:0] d, input logic relu, input logic rdy);
        pe_out_pk.data     = d;
        pe_out_pk.PE_state = st;
        relu_en            = relu;
        out_ready          = rdy;
        @(posedge clk);
        model_step(st == PE_DONE, d, relu, rdy);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- quantization vector table ----------------
    typedef struct {
        logic [DATA_WID-1:0] data;
        logic                relu;
        logic [OUT_WID-1:0]  exp;
    } qvec_t;

    qvec_t qv[11];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT_WID-1:0] bp_data[4];
        int                 bp_idx[4];
        PE_STATE            st;
        int                 rdy_pct;

        qv[0]  = '{16'h0123, 1'b0, 8'h12};
        qv[1]  = '{16'hFE00, 1'b1, 8'h00};
        qv[2]  = '{16'hFE00, 1'b0, 8'hE0};
        qv[3]  = '{16'h7FF0, 1'b0, 8'h7F};
        qv[4]  = '{16'h8000, 1'b0, 8'h80};
        qv[5]  = '{16'hFFFF, 1'b0, 8'hFF};
        qv[6]  = '{16'h07F0, 1'b0, 8'h7F};
        qv[7]  = '{16'h0800, 1'b0, 8'h7F};
        qv[8]  = '{16'hF800, 1'b0, 8'h80};
        qv[9]  = '{16'hF7F0, 1'b0, 8'h80};
        qv[10] = '{16'h0100, 1'b1, 8'h10};

        bp_data = '{8'h01, 8'h02, 8'h03, 8'h04};
        bp_idx  = '{0, 1, 2, 0};

        // Reset state, observed while reset is held.
        set_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_pe_hold", pe_hold, 0);
        check("rst_overflow", overflow_err, 0);
        reset = 1'b0;
        model_reset();

        // Quantization table with N+2 latency check.
        for (int i = 0; i < 11; i++) begin
            cycle(PE_DONE, qv[i].data, qv[i].relu, 1'b1);
            check("q_n1_valid", out_valid, 0);
            cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);
            check("q_n2_valid", out_valid, 1);
            check("q_data", out_data, qv[i].exp);
            if (i == 0) begin
                check("q_first_idx", out_idx, 0);
                check("q_first_last", out_last, 0);
            end
            cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);
        end
        check("q_no_overflow", overflow_err, 0);

        // Backpressure and overflow.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            cycle(PE_DONE, DATA_WID'(i << 4), 1'b0, 1'b0);
            if (i == 3) check("bp_hold_low", pe_hold, 0);
            if (i == 4) check("bp_hold_high", pe_hold, 1);
        end
        cycle(PE_ACC, 16'h0000, 1'b0, 1'b0);
        check("bp_overflow", overflow_err, 1);
        check("bp_hold", pe_hold, 1);
        for (int k = 0; k < 4; k++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, bp_data[k]);
            check("bp_idx", out_idx, bp_idx[k]);
            check("bp_last", out_last, k == 2);
            cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);
        end
        check("bp_empty", out_valid, 0);

        // Simultaneous push and pop while full.
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(PE_DONE, DATA_WID'(i << 4), 1'b0, 1'b0);
        cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);
        check("full_pp_overflow", overflow_err, 0);
        for (int k = 0; k < 4; k++) begin
            check("full_pp_valid", out_valid, 1);
            check("full_pp_data", out_data, k + 2);
            cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);
        end
        check("full_pp_empty", out_valid, 0);

        // Asynchronous reset with two words buffered.
        do_reset();
        cycle(PE_DONE, 16'h0010, 1'b0, 1'b1);
        cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);
        cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);
        cycle(PE_DONE, 16'h0020, 1'b0, 1'b0);
        cycle(PE_DONE, 16'h0030, 1'b0, 1'b0);
        cycle(PE_ACC, 16'h0000, 1'b0, 1'b0);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_idx", out_idx, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_hold", pe_hold, 0);
        check("arst_overflow", overflow_err, 0);
        check("arst_idx", out_idx, 0);
        check("arst_last", out_last, 0);
        set_idle();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cycle(PE_DONE, 16'h0050, 1'b0, 1'b1);
        cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_data", out_data, 8'h05);
        check("post_rst_idx", out_idx, 0);
        cycle(PE_ACC, 16'h0000, 1'b0, 1'b1);

        // Randomized traffic in phases of differing downstream readiness.
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            rdy_pct = (ph == 0) ? 90 : ((ph == 1) ? 30 : 60);
            for (int n = 0; n < 200; n++) begin
                if ($urandom_range(0, 99) < 55) st = PE_DONE;
                else                            st = PE_STATE'($urandom_range(0, 2));
                cycle(st, DATA_WID'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 99) < rdy_pct));
            end
        end
        for (int n = 0; n < 8; n++) cycle(PE_IDLE, 16'h0000, 1'b0, 1'b1);
        check("rand_drained", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
